// File: rtl/bsg_upstream_out_pkg.sv
// Shared types and elaboration helpers for the upstream output serializer.
package bsg_upstream_out_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int calc_beats(int word_w, int num_ch, int ch_w);
        return word_w / (num_ch * ch_w);
    endfunction

    function automatic int calc_cnt_w(int credits);
        return $clog2(credits) + 1;
    endfunction

    function automatic int calc_beat_w(int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic bit cfg_ok(int word_w, int num_ch, int ch_w, int credits);
        int beats;
        beats = calc_beats(word_w, num_ch, ch_w);
        return (beats >= 1)
            && (word_w == beats * num_ch * ch_w)
            && (credits >= 2)
            && ((credits & (credits - 1)) == 0);
    endfunction

endpackage

// File: rtl/bsg_upstream_out_serializer_credit_counter.sv
// Sent/finished word counters with token-based credit and underflow flag.
module bsg_upstream_credit_counter
    import bsg_upstream_out_pkg::*;
#(
    parameter int CREDITS = 64,
    parameter int CNT_W   = calc_cnt_w(CREDITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept_i,
    input  logic             token_i,
    output logic             credit_ok_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             token_err_o
);

    logic [CNT_W-1:0] sent_q, sent_d;
    logic [CNT_W-1:0] finish_q, finish_d;
    logic             err_q, err_d;
    logic             none_out;

    // Modular difference stays correct across counter wrap.
    assign outstanding_o = sent_q - finish_q;
    assign none_out      = (outstanding_o == '0);
    assign credit_ok_o   = outstanding_o < CNT_W'(CREDITS);
    assign token_err_o   = err_q;

    always_comb begin
        sent_d   = sent_q;
        finish_d = finish_q;
        err_d    = err_q;
        if (accept_i) begin
            sent_d = sent_q + CNT_W'(1);
        end
        if (token_i) begin
            if (none_out) begin
                err_d = 1'b1;
            end else begin
                finish_d = finish_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sent_q   <= '0;
            finish_q <= '0;
            err_q    <= 1'b0;
        end else begin
            sent_q   <= sent_d;
            finish_q <= finish_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: rtl/bsg_upstream_out_serializer.sv
// Core-word to multi-channel beat serializer with token credit flow control.
// Optional per-channel parity output enabled by BSG_UPSTREAM_OUT_PARITY_EN.
module bsg_upstream_out_serializer
    import bsg_upstream_out_pkg::*;
#(
    parameter int WORD_W  = 64,
    parameter int NUM_CH  = 2,
    parameter int CH_W    = 8,
    parameter int CREDITS = 64,
    localparam int CNT_W  = calc_cnt_w(CREDITS),
    localparam int BW     = NUM_CH * CH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_valid_i,
    input  logic [WORD_W-1:0] core_data_i,
    output logic              core_ready_o,
    input  logic              io_token_i,
    output logic              io_valid_o,
    output logic [BW-1:0]     io_data_o,
    output logic [CNT_W-1:0]  outstanding_o,
`ifdef BSG_UPSTREAM_OUT_PARITY_EN
    output logic [NUM_CH-1:0] io_parity_o,
`endif
    output logic              token_err_o
);

    localparam int BEATS  = calc_beats(WORD_W, NUM_CH, CH_W);
    localparam int BEAT_W = calc_beat_w(BEATS);

    if (!cfg_ok(WORD_W, NUM_CH, CH_W, CREDITS)) begin : g_bad_cfg
        $error("bsg_upstream_out_serializer: illegal parameter set");
    end

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              io_valid_q, io_valid_d;
    logic [BW-1:0]     io_data_q, io_data_d;
    logic              credit_ok;
    logic              last_beat;
    logic              slot_free;
    logic              accept;

    assign last_beat    = (beat_q == BEAT_W'(BEATS - 1));
    assign slot_free    = (state_q == IDLE) || last_beat;
    assign core_ready_o = !rst && credit_ok && slot_free;
    assign accept       = core_valid_i && core_ready_o;

    bsg_upstream_credit_counter #(
        .CREDITS(CREDITS),
        .CNT_W  (CNT_W)
    ) u_credit (
        .clk          (clk),
        .rst          (rst),
        .accept_i     (accept),
        .token_i      (io_token_i),
        .credit_ok_o  (credit_ok),
        .outstanding_o(outstanding_o),
        .token_err_o  (token_err_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: if (last_beat && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat 0 is loaded straight from the core so it appears the cycle after accept.
    always_comb begin
        beat_d     = beat_q;
        shift_d    = shift_q;
        io_valid_d = 1'b0;
        io_data_d  = io_data_q;
        if (accept) begin
            io_valid_d = 1'b1;
            io_data_d  = core_data_i[BW-1:0];
            shift_d    = core_data_i >> BW;
            beat_d     = '0;
        end else if (state_q == SEND && !last_beat) begin
            io_valid_d = 1'b1;
            io_data_d  = shift_q[BW-1:0];
            shift_d    = shift_q >> BW;
            beat_d     = beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q     <= '0;
            shift_q    <= '0;
            io_valid_q <= 1'b0;
            io_data_q  <= '0;
        end else begin
            beat_q     <= beat_d;
            shift_q    <= shift_d;
            io_valid_q <= io_valid_d;
            io_data_q  <= io_data_d;
        end
    end

    assign io_valid_o = io_valid_q;
    assign io_data_o  = io_data_q;

`ifdef BSG_UPSTREAM_OUT_PARITY_EN
    logic [NUM_CH-1:0] parity_q, parity_d;

    always_comb begin
        parity_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            parity_d[c] = ^io_data_d[c*CH_W +: CH_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= '0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign io_parity_o = parity_q;
`endif

endmodule
